// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin fetch/data arbiter sequencing MAR load, RAM strobes with
// programmable wait states, and single-cycle acknowledge back to the served requester.
module mem_access_arbiter #(
   parameter int AW          = 8,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          f_ack,
   output logic          d_ack,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] mar_addr,
   output logic          en_mar,
   output logic          ram_re,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);
   typedef enum logic [1:0] {IDLE, LOAD, ACC, RESP} state_t;
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          sel_q, sel_d, last_q, last_d, we_q, we_d, gd;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic          f_ack_q, f_ack_d, d_ack_q, d_ack_d, busy_q, busy_d;
   logic          en_mar_q, en_mar_d, ram_re_q, ram_re_d, ram_we_q, ram_we_d;
   // sel/last_grant: 1 = data requester, 0 = fetch requester
   assign gd = d_req & (~f_req | ~last_q);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (f_req | d_req) begin
            state_d = LOAD;
            sel_d   = gd;
            last_d  = gd;
            we_d    = gd & d_we;
            addr_d  = gd ? d_addr : f_addr;
            wdata_d = gd ? d_wdata : '0;
         end
         LOAD: begin
            state_d = ACC;
            cnt_d   = 4'(WAIT_CYCLES - 1);
         end
         ACC: if (cnt_q == 4'd0) begin
            state_d = RESP;
            rdata_d = we_q ? rdata_q : ram_rdata;
         end else cnt_d = cnt_q - 4'd1;
         RESP: state_d = IDLE;
      endcase
      en_mar_d = state_d == LOAD;
      ram_re_d = state_d == ACC & ~we_d;
      ram_we_d = state_d == ACC & we_d;
      f_ack_d  = state_d == RESP & ~sel_d;
      d_ack_d  = state_d == RESP & sel_d;
      busy_d   = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         en_mar_q <= 1'b0;
         ram_re_q <= 1'b0;
         ram_we_q <= 1'b0;
         f_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         en_mar_q <= en_mar_d;
         ram_re_q <= ram_re_d;
         ram_we_q <= ram_we_d;
         f_ack_q  <= f_ack_d;
         d_ack_q  <= d_ack_d;
         busy_q   <= busy_d;
      end
   end
   assign f_ack     = f_ack_q;
   assign d_ack     = d_ack_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign mar_addr  = addr_q;
   assign en_mar    = en_mar_q;
   assign ram_re    = ram_re_q;
   assign ram_we    = ram_we_q;
   assign ram_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed checks of arbitration, strobe timing and reset,
// with a WAIT_CYCLES=1 instance and a WAIT_CYCLES=4 instance sharing stimulus.
module tb_mem_access_arbiter;
   logic        clk, rst, f_req, d_req, d_we;
   logic [7:0]  f_addr, d_addr;
   logic [15:0] d_wdata, ram_rdata;
   logic        f_ack, d_ack, busy, en_mar, ram_re, ram_we;
   logic [15:0] rdata, ram_wdata;
   logic [7:0]  mar_addr;
   logic        f_ack4, d_ack4, busy4, en_mar4, ram_re4, ram_we4;
   logic [15:0] rdata4, ram_wdata4;
   logic [7:0]  mar_addr4;
   int          checks, failures;

   mem_access_arbiter #(.AW(8), .DW(16), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .f_ack(f_ack), .d_ack(d_ack), .rdata(rdata),
      .busy(busy), .mar_addr(mar_addr), .en_mar(en_mar), .ram_re(ram_re), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   mem_access_arbiter #(.AW(8), .DW(16), .WAIT_CYCLES(4)) u_dut4 (
      .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .d_req(d_req), .d_we(d_we),
      .d_addr(d_addr), .d_wdata(d_wdata), .f_ack(f_ack4), .d_ack(d_ack4), .rdata(rdata4),
      .busy(busy4), .mar_addr(mar_addr4), .en_mar(en_mar4), .ram_re(ram_re4), .ram_we(ram_we4),
      .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      f_req = 1'b0;
      d_req = 1'b0;
      d_we = 1'b0;
      f_addr = '0;
      d_addr = '0;
      d_wdata = '0;
      ram_rdata = '0;
      #2 rst = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_en_mar", en_mar, 0);
      chk("rst_mar_addr", mar_addr, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_strobes", {ram_re, ram_we, f_ack, d_ack}, 0);
      rst = 1'b1;
      tick();
      // single fetch read
      f_req = 1'b1;
      f_addr = 8'h10;
      ram_rdata = 16'hBEEF;
      tick();
      chk("f_load_en", en_mar, 1);
      chk("f_load_addr", mar_addr, 8'h10);
      chk("f_load_re", ram_re, 0);
      chk("f_load_busy", busy, 1);
      tick();
      chk("f_acc_re", ram_re, 1);
      chk("f_acc_we", ram_we, 0);
      chk("f_acc_en", en_mar, 0);
      chk("f_acc_ack", f_ack, 0);
      tick();
      chk("f_resp_ack", {f_ack, d_ack}, 2'b10);
      chk("f_resp_rdata", rdata, 16'hBEEF);
      chk("f_resp_re", ram_re, 0);
      f_req = 1'b0;
      tick();
      chk("f_idle_ack", f_ack, 0);
      chk("f_idle_busy", busy, 0);
      chk("f_idle_mar", mar_addr, 8'h10);
      // data write
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 8'h2A;
      d_wdata = 16'h1234;
      ram_rdata = 16'h7777;
      tick();
      chk("w_load_addr", mar_addr, 8'h2A);
      tick();
      chk("w_acc_we", ram_we, 1);
      chk("w_acc_re", ram_re, 0);
      chk("w_acc_wdata", ram_wdata, 16'h1234);
      tick();
      chk("w_resp_we", ram_we, 0);
      chk("w_resp_ack", {f_ack, d_ack}, 2'b01);
      chk("w_resp_rdata", rdata, 16'hBEEF);
      d_req = 1'b0;
      tick();
      chk("w_idle_ack", d_ack, 0);
      // stability of latched address/data
      d_req = 1'b1;
      d_addr = 8'h33;
      d_wdata = 16'h5555;
      tick();
      d_addr = 8'h44;
      d_wdata = 16'hAAAA;
      chk("s_load_addr", mar_addr, 8'h33);
      tick();
      d_req = 1'b0;
      chk("s_acc_addr", mar_addr, 8'h33);
      chk("s_acc_wdata", ram_wdata, 16'h5555);
      chk("s_acc_we", ram_we, 1);
      tick();
      chk("s_resp_ack", d_ack, 1);
      tick();
      // contention from reset release
      rst = 1'b0;
      d_we = 1'b0;
      f_addr = 8'h01;
      d_addr = 8'h02;
      f_req = 1'b1;
      d_req = 1'b1;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c_load_en", en_mar, 1);
         chk("c_load_addr", mar_addr, (i % 2) ? 8'h02 : 8'h01);
         tick();
         chk("c_acc_ack", {f_ack, d_ack}, 0);
         tick();
         chk("c_resp_ack", {f_ack, d_ack}, (i % 2) ? 2'b01 : 2'b10);
         tick();
         chk("c_idle_ack", {f_ack, d_ack}, 0);
         chk("c_idle_busy", busy, 0);
      end
      // reset mid-ACC after a fetch grant
      d_req = 1'b0;
      f_addr = 8'h51;
      tick();
      chk("r_load_addr", mar_addr, 8'h51);
      tick();
      chk("r_acc_re", ram_re, 1);
      #1 rst = 1'b0;
      #1;
      chk("r_async_re", ram_re, 0);
      chk("r_async_busy", busy, 0);
      chk("r_async_mar", mar_addr, 0);
      tick();
      chk("r_no_ack", {f_ack, d_ack}, 0);
      rst = 1'b1;
      f_req = 1'b1;
      d_req = 1'b1;
      f_addr = 8'h61;
      d_addr = 8'h62;
      tick();
      chk("r_first_grant", mar_addr, 8'h61);
      // WAIT_CYCLES=4 read on the second instance
      rst = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      d_req = 1'b1;
      d_we = 1'b0;
      d_addr = 8'h50;
      ram_rdata = 16'h0F0F;
      tick();
      chk("w4_load_en", en_mar4, 1);
      chk("w4_load_re", ram_re4, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("w4_acc_re", ram_re4, 1);
         chk("w4_acc_ack", d_ack4, 0);
         ram_rdata = 16'h1000 + 16'(i);
      end
      tick();
      chk("w4_resp_ack", d_ack4, 1);
      chk("w4_resp_re", ram_re4, 0);
      chk("w4_rdata", rdata4, 16'h1003);
      d_req = 1'b0;
      tick();
      chk("w4_idle_ack", d_ack4, 0);
      chk("w4_hold_rdata", rdata4, 16'h1003);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences every main-memory access in the 16-bit CPU.
- Arbitrates between the instruction-fetch requester (PC side) and the data requester (load/store side).
- Drives the MAR load enable and address, and times RAM read/write strobes with a programmable wait-state count.
- Returns read data and a one-cycle acknowledge to the requester it served.

Parameters:
AW, 8, address width; matches MAR width
DW, 16, data width
WAIT_CYCLES, 1, RAM access cycles per transaction; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active low
f_req  input  1  fetch request; level, held until f_ack
f_addr  input  AW  fetch address
d_req  input  1  data request; level, held until d_ack
d_we  input  1  data request is a write (1) or a read (0)
d_addr  input  AW  data address
d_wdata  input  DW  data write value
f_ack  output  1  one-cycle fetch completion pulse
d_ack  output  1  one-cycle data completion pulse
rdata  output  DW  read data; valid in the ack cycle, then held
busy  output  1  high in every state except IDLE
mar_addr  output  AW  address presented to MAR addrin
en_mar  output  1  MAR load enable
ram_re  output  1  RAM read strobe
ram_we  output  1  RAM write strobe
ram_wdata  output  DW  RAM write data
ram_rdata  input  DW  RAM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; internal latches and wait counter clear.
  - last_grant resets to DATA, so the first contended grant goes to fetch.
- FSM states: IDLE, LOAD, ACC, RESP. All are registered; outputs decode from registered state and latches only.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one requester has req=1, grant it. If both have req=1, grant the one that is not last_grant (round-robin).
  - On grant: latch sel, addr, we and wdata, update last_grant, go to LOAD. A fetch grant always latches we=0.
- LOAD (1 cycle): en_mar=1, mar_addr=latched addr. Load counter to WAIT_CYCLES-1. Go to ACC.
- ACC (WAIT_CYCLES cycles):
  - ram_we=latched we; ram_re=~latched we; ram_wdata=latched wdata.
  - All three are held constant for the full ACC period.
  - Counter decrements each cycle; leave ACC when it is 0.
  - On the final ACC edge, a read latches ram_rdata into rdata. A write leaves rdata unchanged.
- RESP (1 cycle): assert f_ack or d_ack per sel, never both. Go to IDLE.
- Latency:
  - With req sampled at edge k, ack is high during the cycle after edge k+1+WAIT_CYCLES.
  - WAIT_CYCLES=1: the ack cycle is the 3rd cycle after edge k.
  - Back-to-back transactions have one IDLE cycle between RESP and the next LOAD.
- Requests and latches:
  - A req that drops during LOAD, ACC or RESP does not abort the transaction; ack is still issued.
  - A req still high in IDLE after its ack counts as a new request.
  - Address and data inputs may change after grant without effect.
- mar_addr holds the latched address outside LOAD; en_mar is 0 outside LOAD.
- Reset mid-transaction: abort immediately, no ack, RAM strobes drop asynchronously.
- The counter is 4 bits. WAIT_CYCLES outside 1..15 is illegal and unchecked.

Test Plan:
- Single fetch read, WAIT_CYCLES=1: f_req=1, f_addr=8'h10, ram_rdata=16'hBEEF.
  -> en_mar=1 for 1 cycle with mar_addr=8'h10; ram_re=1 for 1 cycle.
  -> f_ack one-cycle pulse 3 cycles after the sampling edge; rdata=16'hBEEF; d_ack stays 0.
- Data write: d_req=1, d_we=1, d_addr=8'h2A, d_wdata=16'h1234.
  -> ram_we=1 with ram_wdata=16'h1234 for exactly WAIT_CYCLES cycles; ram_re=0.
  -> d_ack one-cycle pulse; rdata unchanged from its previous value.
- Contention, both req held high from reset release:
  -> grants alternate fetch, data, fetch, data.
  -> each ack is a single-cycle pulse; exactly one IDLE cycle between RESP and the next LOAD.
- WAIT_CYCLES=4 read: ram_re high for 4 consecutive cycles.
  -> ack 6 cycles after the sampling edge; rdata equals ram_rdata at the final ACC edge.
- Stability: change d_addr and d_wdata after grant, and drop d_req during ACC.
  -> mar_addr and ram_wdata keep the latched values; d_ack still pulses.
- Reset mid-ACC: assert rst=0 during ACC.
  -> all outputs 0 immediately; no ack; after release, the first contended grant goes to fetch.
